// File: rtl/param_rr_arbiter_pkg.sv
// Shared widths and types for the param-module arbiter and the blocks that talk to it.
package param_pkg;

   localparam int unsigned NUM_REQ         = 4;
   localparam int unsigned PARAM_WIDTH     = 32;
   localparam int unsigned MAX_NUM_LAYERS  = 16;
   localparam int unsigned MAX_OUTSTANDING = 4;

   // One extra bit so a layer index can address MAX_NUM_LAYERS itself.
   localparam int unsigned ADDR_W = $clog2(MAX_NUM_LAYERS) + 1;
   localparam int unsigned ID_W   = $clog2(NUM_REQ);
   localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING) + 1;

   typedef logic [ADDR_W-1:0]      layer_addr_t;
   typedef logic [ID_W-1:0]        req_id_t;
   typedef logic [PARAM_WIDTH-1:0] param_data_t;

endpackage

// File: rtl/param_rr_arbiter_if.sv
// Requester-side bus: per-requester address channel plus broadcast response channel.
interface param_rr_arbiter_if #(
   parameter int unsigned NUM_REQ     = param_pkg::NUM_REQ,
   parameter int unsigned PARAM_WIDTH = param_pkg::PARAM_WIDTH,
   parameter int unsigned AW          = param_pkg::ADDR_W
);

   logic [NUM_REQ*AW-1:0]  req_addr;
   logic [NUM_REQ-1:0]     req_addr_valid;
   logic [NUM_REQ-1:0]     req_addr_ready;
   logic [PARAM_WIDTH-1:0] rsp_data;
   logic [NUM_REQ-1:0]     rsp_valid;
   logic [NUM_REQ-1:0]     rsp_ready;

   // Requesters drive addresses and response ready.
   modport master (
      output req_addr, req_addr_valid, rsp_ready,
      input  req_addr_ready, rsp_data, rsp_valid
   );

   // The arbiter accepts addresses and returns responses.
   modport slave (
      input  req_addr, req_addr_valid, rsp_ready,
      output req_addr_ready, rsp_data, rsp_valid
   );

endinterface

// File: rtl/param_rr_arbiter_id_fifo.sv
// Small synchronous FIFO holding the requester ID of each in-flight param request.
module param_id_fifo #(
   parameter int unsigned Depth = 4,
   parameter int unsigned IdW   = 2,
   localparam int unsigned CntW = $clog2(Depth) + 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            push,
   input  logic [IdW-1:0]  push_id,
   input  logic            pop,
   output logic [IdW-1:0]  head_id,
   output logic            full,
   output logic            empty,
   output logic [CntW-1:0] count
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

   logic [IdW-1:0]  mem_q [Depth];
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0] count_q;
   logic            do_push, do_pop;

   assign full    = (count_q == CntW'(Depth));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign head_id = mem_q[rd_ptr_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Pointer wrap is explicit so non-power-of-two depths work.
   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
   endfunction

   // Storage, pointers and occupancy; storage itself needs no reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_id;
            wr_ptr_q        <= ptr_inc(wr_ptr_q);
         end
         if (do_pop) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/param_rr_arbiter.sv
// Round-robin arbiter sharing one param module among NUM_REQ requesters.
// Addresses go out through a one-entry registered slot; responses return in order
// and are steered to their owner using the ID FIFO head.
module param_rr_arbiter #(
   parameter int unsigned NUM_REQ         = param_pkg::NUM_REQ,
   parameter int unsigned PARAM_WIDTH     = param_pkg::PARAM_WIDTH,
   parameter int unsigned MAX_NUM_LAYERS  = param_pkg::MAX_NUM_LAYERS,
   parameter int unsigned MAX_OUTSTANDING = param_pkg::MAX_OUTSTANDING,
   localparam int unsigned AW             = $clog2(MAX_NUM_LAYERS) + 1,
   localparam int unsigned CW             = $clog2(MAX_OUTSTANDING) + 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   param_rr_arbiter_if.slave      req_bus,
   output logic [AW-1:0]          param_addr_p,
   output logic                   param_addr_valid_p,
   input  logic                   param_addr_ready_p,
   input  logic [PARAM_WIDTH-1:0] param_data_p,
   input  logic                   param_data_valid_p,
   output logic                   param_data_ready_p,
   output logic [CW-1:0]          outstanding_cnt,
   output logic                   err_spurious_rsp
);

   localparam int unsigned IdW = $clog2(NUM_REQ);

   logic [IdW-1:0] rr_ptr_q;
   logic [IdW-1:0] winner;
   logic [IdW-1:0] scan_idx;
   logic [IdW-1:0] head_id;
   logic           any_valid;
   logic           accept;
   logic           pop;
   logic           fifo_full, fifo_empty;

   // Pick the first valid requester at or after rr_ptr, wrapping around.
   always_comb begin
      any_valid = 1'b0;
      winner    = '0;
      scan_idx  = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         scan_idx = IdW'((32'(rr_ptr_q) + k) % NUM_REQ);
         if (!any_valid && req_bus.req_addr_valid[scan_idx]) begin
            any_valid = 1'b1;
            winner    = scan_idx;
         end
      end
   end

   // A full FIFO blocks accepts even when a pop is in flight this cycle.
   assign accept = any_valid && (!param_addr_valid_p || param_addr_ready_p) && !fifo_full;
   assign pop    = param_data_valid_p && param_data_ready_p;

   // Handshake and response steering toward the requesters.
   always_comb begin
      req_bus.req_addr_ready = '0;
      req_bus.rsp_valid      = '0;
      req_bus.rsp_data       = param_data_p;
      param_data_ready_p     = 1'b0;
      if (accept) begin
         req_bus.req_addr_ready[winner] = 1'b1;
      end
      if (!fifo_empty) begin
         req_bus.rsp_valid[head_id] = param_data_valid_p;
         param_data_ready_p         = req_bus.rsp_ready[head_id];
      end
   end

   // Output address slot, round-robin pointer and sticky spurious-response flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         param_addr_p       <= '0;
         param_addr_valid_p <= 1'b0;
         rr_ptr_q           <= '0;
         err_spurious_rsp   <= 1'b0;
      end else begin
         if (accept) begin
            param_addr_p       <= req_bus.req_addr[winner*AW +: AW];
            param_addr_valid_p <= 1'b1;
            rr_ptr_q           <= (winner == IdW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
         end else if (param_addr_ready_p) begin
            param_addr_valid_p <= 1'b0;
         end
         if (param_data_valid_p && fifo_empty) begin
            err_spurious_rsp <= 1'b1;
         end
      end
   end

   param_id_fifo #(
      .Depth (MAX_OUTSTANDING),
      .IdW   (IdW)
   ) u_id_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (accept),
      .push_id (winner),
      .pop     (pop),
      .head_id (head_id),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (outstanding_cnt)
   );

endmodule

// File: doc/param_rr_arbiter.md
Name: param_rr_arbiter

Overview:
N-port round-robin arbiter that shares a single param module between NUM_REQ requesters, such as per-layer read controllers and write controllers. Each requester issues layer addresses on a valid/ready address channel. The block forwards the addresses to the param module through a one-entry registered stage. It tracks in-flight requests in an ID FIFO and routes the param module's in-order data responses back to the requester that issued each one. Up to MAX_OUTSTANDING requests may be in flight.

Parameters:
NUM_REQ, 4, number of requesters; must be ≥2.
PARAM_WIDTH, 32, param data width.
MAX_NUM_LAYERS, 16, layer count; address width AW = $clog2(MAX_NUM_LAYERS)+1.
MAX_OUTSTANDING, 4, ID FIFO depth (in-flight limit); must be ≥1.

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
req_addr  in  NUM_REQ*AW  packed per-requester layer address; lane i is bits [i*AW +: AW]
req_addr_valid  in  NUM_REQ  address valid, one bit per requester
req_addr_ready  out  NUM_REQ  address accepted, one bit per requester
rsp_data  out  PARAM_WIDTH  response data, broadcast to all requesters
rsp_valid  out  NUM_REQ  response valid, one-hot to the owning requester
rsp_ready  in  NUM_REQ  requester response ready
param_addr_p  out  AW  address to param module (registered)
param_addr_valid_p  out  1  address valid to param module (registered)
param_addr_ready_p  in  1  param module address ready
param_data_p  in  PARAM_WIDTH  param module data
param_data_valid_p  in  1  param module data valid
param_data_ready_p  out  1  data ready to param module
outstanding_cnt  out  $clog2(MAX_OUTSTANDING)+1  ID FIFO occupancy
err_spurious_rsp  out  1  sticky flag: data arrived with no request in flight

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - param_addr_valid_p=0, param_addr_p=0, rr_ptr=0, ID FIFO empty, outstanding_cnt=0, err_spurious_rsp=0.
  - Combinational outputs settle to 0 because the FIFO is empty and the slot is invalid.
  - Reset mid-operation discards all in-flight IDs. Responses for those requests arriving later raise err_spurious_rsp.
- Arbitration (combinational):
  - Winner is the first i with req_addr_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
- Accept condition:
  - accept = any valid & (!param_addr_valid_p | param_addr_ready_p) & !fifo_full.
  - req_addr_ready[winner] = accept. All other ready bits = 0.
  - Ready does not depend on any bit's own valid other than through winner selection.
- On accept (at clk edge):
  - param_addr_p <= req_addr[winner]; param_addr_valid_p <= 1.
  - Push winner ID into the FIFO.
  - rr_ptr <= (winner+1) mod NUM_REQ.
  - Latency from requester handshake to param_addr_valid_p is 1 cycle.
- Slot drain: if param_addr_ready_p=1 and there is no accept, param_addr_valid_p <= 0. param_addr_p holds its value while valid and not ready.
- No winner: rr_ptr unchanged.
- FIFO full: no accept, even if a pop occurs in the same cycle. Accept resumes the cycle after the pop.
- Response path (combinational, zero latency):
  - head = FIFO head ID. rsp_data = param_data_p.
  - rsp_valid[head] = param_data_valid_p & !fifo_empty; all other bits 0.
  - param_data_ready_p = !fifo_empty & rsp_ready[head].
  - Pop on param_data_valid_p & param_data_ready_p.
  - Response ordering equals request-accept order; the param module must return in order.
- Spurious response: if param_data_valid_p=1 while the FIFO is empty, err_spurious_rsp <= 1, held until reset. param_data_ready_p stays 0.
- Simultaneous push and pop when not full: both take effect; outstanding_cnt unchanged.

Decomposition:
- Shared package param_pkg:
  - PARAM_WIDTH, MAX_NUM_LAYERS.
  - localparam ADDR_W = $clog2(MAX_NUM_LAYERS)+1.
  - typedef logic [ADDR_W-1:0] layer_addr_t.
  - Requester ID typedef sized by $clog2(NUM_REQ).
- Sub-module param_id_fifo:
  - Synchronous FIFO, depth MAX_OUTSTANDING, width $clog2(NUM_REQ).
  - push/pop/full/empty/count, with synchronous active-low reset.

Test Plan:
1. Req 2 sends addr 5, param ready=1 → next cycle param_addr_p=5, valid_p=1, outstanding_cnt=1. Return data 0xCAFE → rsp_valid=4'b0100, rsp_data=0xCAFE, count returns to 0.
2. All 4 valid continuously, param ready=1 → grants 0,1,2,3,0 on consecutive cycles; param_addr_p follows each requester's address.
3. param_addr_ready_p pulses and no data returns → after 4 accepts, req_addr_ready=0 and outstanding_cnt=4. One response pops → an accept occurs on the following cycle, not the same cycle.
4. Head owner is requester 1 with rsp_ready[1]=0 and data valid → param_data_ready_p=0, rsp_valid=4'b0010 held, other lanes 0. Raise rsp_ready[1] → pop in that cycle.
5. param_data_valid_p=1 with FIFO empty → err_spurious_rsp=1 next cycle and stays 1; param_data_ready_p=0.
6. Assert rst_n=0 for 1 cycle with 3 outstanding and slot valid → next cycle valid_p=0, outstanding_cnt=0, rr_ptr=0; requester 0 wins first after reset.
